// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl.
//   cfg_valid : new half-period offered (master -> slave)
//   cfg_half  : offered half-period count, WIDTH bits (master -> slave)
//   cfg_ready : controller can accept a configuration (slave -> master)
//   cfg_err   : one-cycle pulse after a rejected (zero) configuration (slave -> master)
interface clk_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller.
// Generates a registered, glitch-free divided clock whose high and low phases
// each last 'active' clk cycles. A new half-period can be offered at any time
// over the cfg handshake; while the divider runs it is staged in a shadow
// register and takes effect on the next phase boundary so no phase is cut short.
// Ports:
//   clk      : system clock, rising-edge
//   rst_n    : asynchronous active-low reset
//   en       : level request to run the divided clock
//   cfg      : configuration handshake (clk_div_ctrl_if.slave)
//   clk_out  : divided clock, driven directly from a flop
//   tick     : one-cycle pulse in the first cycle clk_out reads high
//   running  : high whenever the controller is not idle
module clk_div_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  clk_div_ctrl_if.slave  cfg,
  output logic           clk_out,
  output logic           tick,
  output logic           running
);

  localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             err_q;

  logic             hs;
  logic             terminal;
  logic             abort;
  logic             wrap;

  assign cfg.cfg_ready = !pending;
  assign cfg.cfg_err   = err_q;

  always_comb begin
    hs       = cfg.cfg_valid && !pending;
    terminal = (state != IDLE) && (counter == active - ONE);
    // Dropping en during a low phase abandons the phase immediately; this
    // takes priority over a coincident terminal cycle so no rising edge escapes.
    abort    = (state == RUN) && !en && !clk_out;
    wrap     = terminal && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      active  <= DEF_HALF;
      shadow  <= '0;
      pending <= 1'b0;
      err_q   <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      tick  <= 1'b0;
      err_q <= 1'b0;

      // A handshake can only happen while pending is clear, so it never
      // collides with the shadow-to-active copy below. A handshake on a
      // terminal cycle therefore lands in shadow and waits one more phase.
      if (hs) begin
        if (cfg.cfg_half == '0) begin
          err_q <= 1'b1;
        end else if (state == IDLE) begin
          active <= cfg.cfg_half;
        end else begin
          shadow  <= cfg.cfg_half;
          pending <= 1'b1;
        end
      end

      if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          counter <= '0;
          clk_out <= 1'b0;
          if (en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (abort) begin
            state   <= IDLE;
            running <= 1'b0;
            counter <= '0;
          end else if (wrap) begin
            clk_out <= !clk_out;
            tick    <= !clk_out;
            counter <= '0;
            // Here en low implies clk_out high: the high phase just completed.
            if (!en) begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end else begin
            counter <= counter + ONE;
            // High phase with en low: finish it out in STOP.
            if (!en) state <= STOP;
          end
        end

        STOP: begin
          if (wrap) begin
            clk_out <= !clk_out;
            tick    <= !clk_out;
            counter <= '0;
            if (en) begin
              state <= RUN;
            end else begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end else begin
            counter <= counter + ONE;
            if (en) state <= RUN;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          counter <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  logic en;
  logic clk_out;
  logic tick;
  logic running;

  int checks;
  int errors;

  clk_div_ctrl_if #(.WIDTH(WIDTH)) cfg ();

  clk_div_ctrl #(
    .WIDTH        (WIDTH),
    .DEFAULT_HALF (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check reset outputs, then release with en_val.
  task automatic do_reset(input logic en_val);
    rst_n         = 1'b0;
    en            = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_half  = '0;
    step();
    step();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    chk("rst_cfg_err", cfg.cfg_err, 0);
    chk("rst_cfg_ready", cfg.cfg_ready, 1);
    rst_n = 1'b1;
    en    = en_val;
  endtask

  // Run n cycles; patterns are written first-cycle-first (MSB = first cycle).
  task automatic check_seq(input string tag, input int n,
                           input logic [31:0] co, input logic [31:0] tk);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_clk%0d", tag, i), clk_out, co[n-1-i]);
      chk($sformatf("%s_tick%0d", tag, i), tick, tk[n-1-i]);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    en            = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_half  = '0;

    // Free-running with default half-period 3: period 6, tick on first high cycle.
    do_reset(1'b1);
    check_seq("run", 12, 32'b000111000111, 32'b000100000100);
    chk("run_running", running, 1);

    // Reconfigure to 5 during the first high cycle.
    do_reset(1'b1);
    check_seq("cfg5_a", 4, 32'b0001, 32'b0001);
    chk("cfg5_ready_before", cfg.cfg_ready, 1);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 8'd5;
    step();
    cfg.cfg_valid = 1'b0;
    chk("cfg5_ready_c5", cfg.cfg_ready, 0);
    chk("cfg5_clk_c5", clk_out, 1);
    step();
    chk("cfg5_ready_c6", cfg.cfg_ready, 0);
    chk("cfg5_clk_c6", clk_out, 1);
    step();
    chk("cfg5_ready_c7", cfg.cfg_ready, 1);
    chk("cfg5_clk_c7", clk_out, 0);
    check_seq("cfg5_b", 10, 32'b0000111110, 32'b0000100000);

    // en dropped on first high cycle: high phase completes in STOP.
    do_reset(1'b1);
    check_seq("stop_a", 4, 32'b0001, 32'b0001);
    en = 1'b0;
    step();
    chk("stop_clk_c5", clk_out, 1);
    chk("stop_run_c5", running, 1);
    step();
    chk("stop_clk_c6", clk_out, 1);
    chk("stop_run_c6", running, 1);
    step();
    chk("stop_clk_c7", clk_out, 0);
    chk("stop_run_c7", running, 0);
    step();
    chk("stop_clk_c8", clk_out, 0);
    chk("stop_run_c8", running, 0);
    // en dropped in the low phase: idle on the next edge, counter cleared.
    en = 1'b1;
    step();
    chk("low_run_c1", running, 1);
    step();
    chk("low_clk_c2", clk_out, 0);
    en = 1'b0;
    step();
    chk("low_run_idle", running, 0);
    chk("low_clk_idle", clk_out, 0);
    en = 1'b1;
    check_seq("low_restart", 4, 32'b0001, 32'b0001);

    // Zero configuration rejected: error pulse, period unchanged.
    do_reset(1'b1);
    check_seq("zero_a", 2, 32'b00, 32'b00);
    chk("zero_err_before", cfg.cfg_err, 0);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 8'd0;
    step();
    cfg.cfg_valid = 1'b0;
    chk("zero_err_pulse", cfg.cfg_err, 1);
    chk("zero_clk_c3", clk_out, 0);
    step();
    chk("zero_err_clear", cfg.cfg_err, 0);
    chk("zero_ready", cfg.cfg_ready, 1);
    chk("zero_clk_c4", clk_out, 1);
    chk("zero_tick_c4", tick, 1);
    check_seq("zero_b", 8, 32'b11000111, 32'b00000100);

    // en re-raised while in STOP: phase continues undisturbed.
    do_reset(1'b1);
    check_seq("resume_a", 4, 32'b0001, 32'b0001);
    en = 1'b0;
    step();
    chk("resume_clk_c5", clk_out, 1);
    chk("resume_run_c5", running, 1);
    en = 1'b1;
    step();
    chk("resume_clk_c6", clk_out, 1);
    check_seq("resume_b", 8, 32'b00011100, 32'b00010000);

    // Asynchronous reset mid-run with a pending configuration.
    do_reset(1'b1);
    check_seq("arst_a", 4, 32'b0001, 32'b0001);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 8'd5;
    step();
    cfg.cfg_valid = 1'b0;
    chk("arst_pending", cfg.cfg_ready, 0);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_clk_out", clk_out, 0);
    chk("arst_tick", tick, 0);
    chk("arst_running", running, 0);
    chk("arst_cfg_err", cfg.cfg_err, 0);
    chk("arst_cfg_ready", cfg.cfg_ready, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("arst_quiet_clk%0d", i), clk_out, 0);
      chk($sformatf("arst_quiet_run%0d", i), running, 0);
    end
    en = 1'b1;
    check_seq("arst_b", 10, 32'b0001110001, 32'b0001000001);
    chk("arst_ready_after", cfg.cfg_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the half-period count.
REQ-002 SHALL have parameter DEFAULT_HALF, default 50000000: half-period count in clk cycles loaded at reset.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  level request to run the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new half-period offered.
REQ-007 SHALL have port cfg_half  input  WIDTH  offered half-period count, sampled when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_ready  output  1  controller can accept a configuration.
REQ-009 SHALL have port clk_out  output  1  registered, glitch-free divided clock.
REQ-010 SHALL have port tick  output  1  one-cycle pulse coincident with each clk_out rising edge.
REQ-011 SHALL have port running  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and STOP, plus an active register, a shadow register, a pending flag and a WIDTH-bit counter.
REQ-014 SHALL define the terminal cycle as RUN or STOP with counter == active-1.
REQ-015 SHALL, on the terminal cycle: toggle clk_out, clear the counter, and if pending is set copy shadow to active and clear pending; otherwise the counter increments by 1.
REQ-016 SHALL make each clk_out high phase and low phase last exactly active cycles.
REQ-017 SHALL drive tick high in exactly the cycle in which clk_out first reads 1 after a 0-to-1 toggle; tick is never high in two consecutive cycles unless active==1.
REQ-018 SHALL drive cfg_ready = !pending in every state.
REQ-019 SHALL, on a handshake with cfg_half==0, discard the value, leave active, shadow and pending unchanged, and pulse cfg_err high in the next cycle.
REQ-020 SHALL, on a non-zero handshake in IDLE, load active directly and leave pending clear.
REQ-021 SHALL, on a non-zero handshake in RUN or STOP, load shadow and set pending.
REQ-022 SHALL, when a RUN/STOP handshake coincides with a terminal cycle, apply the new value at the following terminal cycle, not the current one.
REQ-023 SHALL move IDLE->RUN on en==1, with counter=0 and clk_out=0; the first clk_out rise occurs active cycles after entering RUN.
REQ-024 SHALL, on en==0 in RUN with clk_out==0, move to IDLE at the next edge and clear the counter; the low phase may be truncated.
REQ-025 SHALL, on en==0 in RUN with clk_out==1, move to STOP and keep counting.
REQ-026 SHALL move STOP->IDLE on the terminal cycle, with clk_out toggling to 0 and the counter cleared.
REQ-027 SHALL move STOP->RUN on en==1, with no change to the counter or clk_out (no phase disturbance).
REQ-028 SHALL hold clk_out=0, tick=0 and the counter at 0 in IDLE.
REQ-029 SHALL require no glitch on clk_out: it is driven only from a flop.

Reset
REQ-030 SHALL asynchronously, on rst_n==0, force: state=IDLE, clk_out=0, tick=0, running=0, cfg_err=0, counter=0, active=DEFAULT_HALF, shadow=0, pending=0, cfg_ready=1.
REQ-031 SHALL abandon any in-progress phase or pending configuration on reset assertion mid-operation, with no further clk_out edges until en is seen after release.
REQ-032 SHALL honour en on the first clk edge after rst_n deasserts.

Verification (WIDTH=8, DEFAULT_HALF=3)
REQ-033 SHALL check: reset, en=1 held -> clk_out 0 for cycles 1-3 of RUN, 1 for 3 cycles, repeating with period 6; tick high once per period on the first high cycle.
REQ-034 SHALL check: cfg_half=5 accepted mid high phase -> cfg_ready=0 until the next terminal cycle; the current phase ends at 3 cycles, later phases are 5 cycles each.
REQ-035 SHALL check: en dropped on the 1st high cycle -> STOP, clk_out stays high for the full 3 cycles, then 0, running falls the same edge; en dropped in the low phase -> IDLE next edge.
REQ-036 SHALL check: cfg_half=0 handshake -> cfg_err pulses one cycle, period unchanged at 6.
REQ-037 SHALL check: en re-raised in STOP -> clk_out phase continues uninterrupted, period 6 preserved.
REQ-038 SHALL check: rst_n pulsed low mid-RUN with pending set -> all outputs at reset values immediately, active=3 afterwards, and pending is cleared.
